// File: rtl/word_sequencer.sv
// Walks a character word ROM from index 0 to len_string and presents each code
// over a valid/ready handshake, followed by a programmable dwell per character.
module word_sequencer #(
    parameter int CHAR_W      = 4,
    parameter int IDX_W       = 4,
    parameter int HOLD_W      = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [IDX_W-1:0]  len_string,
    input  logic [CHAR_W-1:0] caracter,
    output logic [IDX_W-1:0]  counter_caracter,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        HOLD,
        DONE
    } state_t;

    localparam bit HAS_DWELL = (HOLD_CYCLES > 0);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HAS_DWELL ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  counter_q, counter_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;

    // Outcome of finishing one character: next index, wrap, or end of word.
    state_t           adv_state;
    logic [IDX_W-1:0] adv_counter;
    logic             adv_wrap;

    always_comb begin
        adv_state   = FETCH;
        adv_counter = counter_q + 1'b1;
        adv_wrap    = 1'b0;
        if (counter_q >= len_q) begin
            if (loop_en) begin
                adv_counter = '0;
                adv_wrap    = 1'b1;
            end else begin
                adv_state   = DONE;
                adv_counter = counter_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        len_d     = len_q;
        char_d    = char_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            counter_d = '0;
            char_d    = '0;
            hold_d    = '0;
            valid_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d     = len_string;
                        counter_d = '0;
                        state_d   = FETCH;
                    end
                end
                FETCH: begin
                    char_d  = caracter;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        if (HAS_DWELL) begin
                            hold_d  = HOLD_INIT;
                            state_d = HOLD;
                        end else begin
                            state_d   = adv_state;
                            counter_d = adv_counter;
                            wrap_d    = adv_wrap;
                            done_d    = (adv_state == DONE);
                        end
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d   = adv_state;
                        counter_d = adv_counter;
                        wrap_d    = adv_wrap;
                        done_d    = (adv_state == DONE);
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            len_q     <= '0;
            char_q    <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            len_q     <= len_d;
            char_q    <= char_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign counter_caracter = counter_q;
    assign char_out         = char_q;
    assign char_valid       = valid_q;
    assign busy             = busy_q;
    assign wrap             = wrap_q;
    assign done             = done_q;

endmodule
